mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled on the rising edge.
REQ-005 op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  multiplicand or dividend (rs).
REQ-007 b  input  32  multiplier or divisor (rt).
REQ-008 mthi_we  input  1  write wdata to HI.
REQ-009 mtlo_we  input  1  write wdata to LO.
REQ-010 wdata  input  32  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress; the pipeline stalls MFHI/MFLO/MULT/DIV while busy is high.
REQ-012 done  output  1  one-cycle pulse when HI/LO receive a result.
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIX, and SHALL use a 5-bit iteration counter.
REQ-016 IDLE with start=1 at edge E0: latch op, |a|, |b| (magnitudes only for signed ops) and the sign flags; go to RUN with cnt=0 and busy=1.
REQ-017 RUN SHALL perform one radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide; 32 steps on edges E1..E32; after E32, go to FIX.
REQ-018 FIX at edge E33: apply sign correction, write hi/lo, set done=1 for one cycle, set busy=0, and return to IDLE.
REQ-019 Latency: new hi/lo are visible 33 cycles after the start edge; busy is high for exactly 33 cycles.
REQ-020 Multiply results: hi:lo = 64-bit product. MULT treats a and b as two's complement; MULTU treats them as unsigned.
REQ-021 Divide results: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend (DIV) or unsigned (DIVU).
REQ-022 Divide by zero (b=0, DIV or DIVU): hi=a, lo=32'hFFFFFFFF; no exception and no extra latency.
REQ-023 DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
REQ-024 start while busy=1 SHALL be ignored; the in-flight operation continues unchanged.
REQ-025 start in the cycle where done=1 SHALL be accepted, since busy=0; this allows back-to-back operations.
REQ-026 mthi_we/mtlo_we with busy=0: hi/lo take wdata on that edge. Both asserted together: both registers are written.
REQ-027 mthi_we/mtlo_we with busy=1 SHALL be ignored.
REQ-028 start together with mthi_we or mtlo_we in IDLE: start wins and the write is dropped.
REQ-029 hi/lo SHALL hold their value at all times other than an MT write, the FIX edge, or reset.
REQ-030 op/a/b changes after the start edge SHALL NOT affect the result.

Reset
REQ-031 On reset assertion, immediately and independent of clk: state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0.
REQ-032 Reset mid-operation SHALL discard partial results; no done pulse is produced for the aborted operation.
REQ-033 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-034 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after E33: hi=0xFFFFFFFE, lo=0x00000001; done high exactly one cycle; busy high 33 cycles.
REQ-035 MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-036 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-037 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 Start DIVU 100/7 with start and mthi_we re-asserted at E5 (different operands) -> both ignored; result hi=2, lo=14; new start in the done cycle -> second result exactly 33 cycles later.
REQ-039 Reset pulsed between E10 and E11 of a MULT -> busy=0, hi=lo=0 immediately with no done pulse; subsequent MULTU 3*4 -> lo=12, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers. Signed operations run on
// magnitudes, and the sign is corrected in a final FIX cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div_zero_q, div_zero_d;
    logic [31:0] operand_q, operand_d;
    logic [31:0] work_hi_q, work_hi_d;
    logic [31:0] work_lo_q, work_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        signed_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        signed_op = ~op[0];
        a_neg     = signed_op & a[31];
        b_neg     = signed_op & b[31];
        a_mag     = a_neg ? (~a + 32'd1) : a;
        b_mag     = b_neg ? (~b + 32'd1) : b;

        // Multiply: conditionally add the multiplicand, then shift the 65-bit pair right.
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : 33'd0);

        // Divide: the partial remainder is always below the divisor, so the shifted
        // remainder fits in 33 bits, and the difference fits in 32 bits when taken.
        div_shift = {work_hi_q, work_lo_q[31]};
        div_ge    = (div_shift >= {1'b0, operand_q});
        div_diff  = div_shift[31:0] - operand_q;

        prod_fix  = neg_res_q ? (~{work_hi_q, work_lo_q} + 64'd1) : {work_hi_q, work_lo_q};
        // The remainder path already yields hi=a on a zero divisor; only the quotient is forced.
        quo_fix   = div_zero_q ? 32'hFFFF_FFFF : (neg_res_q ? (~work_lo_q + 32'd1) : work_lo_q);
        rem_fix   = neg_rem_q ? (~work_hi_q + 32'd1) : work_hi_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        operand_d  = operand_q;
        work_hi_d  = work_hi_q;
        work_lo_d  = work_lo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    cnt_d      = 5'd0;
                    busy_d     = 1'b1;
                    is_div_d   = op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (b == 32'd0);
                    work_hi_d  = 32'd0;
                    operand_d  = op[1] ? b_mag : a_mag;
                    work_lo_d  = op[1] ? a_mag : b_mag;
                end else begin
                    if (mthi_we) hi_d = wdata;
                    if (mtlo_we) lo_d = wdata;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    work_hi_d = div_ge ? div_diff : div_shift[31:0];
                    work_lo_d = {work_lo_q[30:0], div_ge};
                end else begin
                    work_hi_d = mul_sum[32:1];
                    work_lo_d = {mul_sum[0], work_lo_q[31:1]};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            operand_q  <= 32'd0;
            work_hi_q  <= 32'd0;
            work_lo_q  <= 32'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            operand_q  <= operand_d;
            work_hi_q  <= work_hi_d;
            work_lo_q  <= work_lo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized bench for mult_div_unit. The expected results come from
// 64-bit integer arithmetic, and the cycle timing is checked against a fixed 33-cycle window.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        mthi_we, mtlo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_hi   = 32'd0;
    logic [31:0] exp_lo   = 32'd0;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi_we (mthi_we),
        .mtlo_we (mtlo_we),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic ref_model(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                             output logic [31:0] rh, output logic [31:0] rl);
        logic signed [63:0] sa, sb, p, q, r;
        logic [63:0] up;
        sa = 64'(signed'(av));
        sb = 64'(signed'(bv));
        case (o)
            2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin up = {32'd0, av} * {32'd0, bv}; rh = up[63:32]; rl = up[31:0]; end
            2'b10: begin
                if (bv == 32'd0) begin rh = av; rl = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; rh = r[31:0]; rl = q[31:0]; end
            end
            default: begin
                if (bv == 32'd0) begin rh = av; rl = 32'hFFFF_FFFF; end
                else begin rh = av % bv; rl = av / bv; end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts on the next edge, returns #1 after the done edge (the done cycle) with start low.
    task automatic do_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit interfere, input bit mt_too);
        logic [31:0] eh, el;
        ref_model(o, av, bv, eh, el);
        op = o; a = av; b = bv; start = 1'b1;
        if (mt_too) begin
            mthi_we = 1'b1; mtlo_we = 1'b1; wdata = $urandom;
        end
        tick();
        start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_after_start", 32'(done), 32'd0);
        chk("hi_hold_start", hi, exp_hi);
        chk("lo_hold_start", lo, exp_lo);
        for (int k = 1; k <= 33; k++) begin
            if (interfere && k == 5) begin
                start = 1'b1; mthi_we = 1'b1; mtlo_we = 1'b1; wdata = $urandom;
                op = 2'b00; a = 32'd55; b = 32'd3;
            end
            tick();
            if (interfere && k == 5) begin
                start = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
            end
            if (k < 33) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_run", 32'(done), 32'd0);
                chk("hi_hold_run", hi, exp_hi);
                chk("lo_hold_run", lo, exp_lo);
            end else begin
                chk("busy_end", 32'(busy), 32'd0);
                chk("done_end", 32'(done), 32'd1);
                chk("hi_result", hi, eh);
                chk("lo_result", lo, el);
            end
        end
        exp_hi = eh;
        exp_lo = el;
        $display("op=%0d a=%h b=%h hi=%h lo=%h exp_hi=%h exp_lo=%h", o, av, bv, hi, lo, eh, el);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = 32'd0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        do_op(2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("divu_zero_hi", hi, 32'd7);
        chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf_hi", hi, 32'd0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);

        // The interfering start and MT write at E5 are ignored; the next start lands in the done cycle.
        do_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0);
        chk("divu_100_7_hi", hi, 32'd2);
        chk("divu_100_7_lo", lo, 32'd14);
        do_op(2'b01, 32'd9, 32'd11, 1'b0, 1'b1);
        chk("b2b_lo", lo, 32'd99);

        // MT writes from the done cycle and from idle.
        mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        mthi_we = 1'b0;
        exp_hi = 32'hDEAD_BEEF;
        chk("mthi_hi", hi, exp_hi);
        chk("mthi_lo_kept", lo, exp_lo);
        chk("mthi_done_clear", 32'(done), 32'd0);
        mthi_we = 1'b1; mtlo_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b0;
        exp_hi = 32'h1234_5678; exp_lo = 32'h1234_5678;
        chk("mt_both_hi", hi, exp_hi);
        chk("mt_both_lo", lo, exp_lo);
        repeat (3) tick();
        chk("idle_hold_hi", hi, exp_hi);
        chk("idle_hold_lo", lo, exp_lo);

        // Reset between E10 and E11 of a MULT aborts it with no done pulse.
        op = 2'b00; a = 32'h0001_2345; b = 32'hFFFF_0007; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        #1 reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle_busy", 32'(busy), 32'd0);
        end
        do_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_lo", lo, 32'd12);

        for (int n = 0; n < 30; n++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 300));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: ra = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            do_op(ro, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
                chk("gap_done_clear", 32'(done), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
